// File: rtl/rate_sel_pkg.sv
// rate_sel_pkg: shared FSM state type, default divisor table and divisor extraction helper
package rate_sel_pkg;

    typedef enum logic {RUN, PEND} state_t;

    localparam int DEF_CNT_W = 26;
    localparam logic [4*DEF_CNT_W-1:0] DEF_DIV_LIST = {26'd50000000, 26'd12500000, 26'd3125000, 26'd1};

    // Widest packed divisor list the helper accepts (16 rates x 32 bits, with headroom)
    localparam int LIST_MAX = 1024;

    // Returns entry k of a packed list whose entries are w bits wide (w <= 32)
    function automatic logic [31:0] div_at(input logic [LIST_MAX-1:0] list, input int k, input int w);
        logic [LIST_MAX-1:0] s;
        s = list >> (k * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/sel_sync_debounce.sv
// sel_sync_debounce: two-flop synchroniser for a switch code with optional stability filter
//   clk, rst_n : system clock, asynchronous active-low reset
//   sel        : raw switch code, asynchronous to clk
//   cand       : synchronised (and, with SEL_DEBOUNCE_EN, debounced) candidate code
//   Optional feature macro: SEL_DEBOUNCE_EN
module sel_sync_debounce
    import rate_sel_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int RESET_SEL  = 0,
    parameter int STABLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] cand
);

    localparam logic [SEL_W-1:0] RST = SEL_W'(RESET_SEL);

    logic [SEL_W-1:0] s1, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST;
            s2 <= RST;
        end else begin
            s1 <= sel;
            s2 <= s1;
        end
    end

`ifdef SEL_DEBOUNCE_EN
    localparam int HW = $clog2(STABLE_CYC + 1);
    localparam logic [HW-1:0] HMAX = HW'(STABLE_CYC - 1);

    // h counts cycles s2 has already been stable minus one; s1 != s2 means s2 changes at this edge
    logic [HW-1:0] h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h    <= '0;
            cand <= RST;
        end else begin
            h <= (s1 != s2) ? '0 : (h == HMAX ? h : h + HW'(1));
            if (h == HMAX) cand <= s2;
        end
    end
`else
    assign cand = s2;
`endif

endmodule

// File: rtl/rate_tick_select.sv
// rate_tick_select: switch-selected clock-enable tick and divided square wave, glitch-free rate changes
//   clk, rst_n : system clock, asynchronous active-low reset
//   sel        : raw switch code selecting one of NUM_RATES divisors
//   tick       : one-cycle pulse every DIV_LIST[activeSel] cycles
//   clkOut     : square wave toggling on every tick
//   activeSel  : rate index currently in force
//   pending    : new rate accepted, waiting for the next tick boundary
//   Optional feature macro: SEL_DEBOUNCE_EN (debounce filter in sel_sync_debounce)
module rate_tick_select
    import rate_sel_pkg::*;
#(
    parameter int                          NUM_RATES  = 4,
    parameter int                          SEL_W      = 2,
    parameter int                          CNT_W      = 26,
    parameter logic [NUM_RATES*CNT_W-1:0]  DIV_LIST   = DEF_DIV_LIST,
    parameter int                          RESET_SEL  = 0,
    parameter int                          STABLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    output logic             tick,
    output logic             clkOut,
    output logic [SEL_W-1:0] activeSel,
    output logic             pending
);

    localparam logic [SEL_W-1:0]    RST  = SEL_W'(RESET_SEL);
    localparam logic [SEL_W:0]      NR   = (SEL_W + 1)'(NUM_RATES);
    localparam logic [LIST_MAX-1:0] LIST = LIST_MAX'(DIV_LIST);

    state_t           state;
    logic [SEL_W-1:0] cand, next_sel;
    logic [CNT_W-1:0] cnt, div_cur;
    logic [CNT_W-1:0] div_tbl [2**SEL_W];
    logic             wrap, valid;

    // Full 2**SEL_W table so activeSel indexes it directly; unused slots are never selected
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_div
        if (i < NUM_RATES) begin : g_v
            localparam logic [31:0] D = div_at(LIST, i, CNT_W);
            assign div_tbl[i] = D[CNT_W-1:0];
        end else begin : g_u
            assign div_tbl[i] = CNT_W'(1);
        end
    end

    sel_sync_debounce #(
        .SEL_W     (SEL_W),
        .RESET_SEL (RESET_SEL),
        .STABLE_CYC(STABLE_CYC)
    ) u_sel (
        .clk  (clk),
        .rst_n(rst_n),
        .sel  (sel),
        .cand (cand)
    );

    assign div_cur = div_tbl[activeSel];
    assign wrap    = cnt == div_cur - CNT_W'(1);
    assign valid   = {1'b0, cand} < NR;

    // The wrap edge is the tick boundary: it emits the old-rate tick and hands over to next_sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tick      <= 1'b0;
            clkOut    <= 1'b0;
            activeSel <= RST;
            next_sel  <= RST;
            pending   <= 1'b0;
            state     <= RUN;
        end else begin
            cnt    <= wrap ? '0 : cnt + CNT_W'(1);
            tick   <= wrap;
            clkOut <= clkOut ^ wrap;
            if (state == RUN) begin
                if (valid && cand != activeSel) begin
                    next_sel <= cand;
                    pending  <= 1'b1;
                    state    <= PEND;
                end
            end else if (wrap) begin
                activeSel <= next_sel;
                pending   <= 1'b0;
                state     <= RUN;
            end else if (cand == activeSel) begin
                pending <= 1'b0;
                state   <= RUN;
            end else if (valid) begin
                next_sel <= cand;
            end
        end
    end

endmodule

// File: tb/tb_rate_tick_select.sv
// tb_rate_tick_select: directed scoreboard bench for rate_tick_select (rates 8,4,2,1; codes 4..7 invalid)
module tb_rate_tick_select;

    logic       clk = 1'b0, rst_n = 1'b1, tick, clkOut, pending;
    logic [2:0] sel = 3'd0, activeSel;

    always #5 clk = ~clk;

    rate_tick_select #(
        .NUM_RATES (4),
        .SEL_W     (3),
        .CNT_W     (4),
        .DIV_LIST  (16'h1248),
        .RESET_SEL (0),
        .STABLE_CYC(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .tick     (tick),
        .clkOut   (clkOut),
        .activeSel(activeSel),
        .pending  (pending)
    );

    typedef struct { int gap; int ck; int asel; } exp_t;

    exp_t q[$];
    int   cyc = 0, n_chk = 0, n_pass = 0, exp_ck = 0;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_state(string name, int p, int a);
        chk({name, "_pending"}, pending, p);
        chk({name, "_asel"}, activeSel, a);
    endtask

    // Expected ticks: gap in cycles since previous tick (or reset release), clkOut and activeSel after it
    task automatic push(int n, int gap, int asel);
        for (int i = 0; i < n; i++) begin
            exp_ck ^= 1;
            q.push_back('{gap, exp_ck, asel});
        end
    endtask

    task automatic at(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int   last;
        exp_t e;
        last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) last = 0;
            else if (tick) begin
                chk("sb_entry", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("tick_gap", cyc - last, e.gap);
                    chk("tick_clkout", clkOut, e.ck);
                    chk("tick_asel", activeSel, e.asel);
                end
                last = cyc;
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_clkout", clkOut, 0);
        chk_state("rst", 0, 0);
        @(negedge clk);
        @(negedge clk);
`ifdef SEL_DEBOUNCE_EN
        push(6, 8, 0);
        push(1, 8, 2);
        push(2, 2, 2);
        rst_n = 1'b1;
        at(2);  sel = 3'd1;
        at(7);  sel = 3'd0;
        at(12); chk_state("glitch_a", 0, 0);
        at(29); chk_state("glitch_b", 0, 0);
        at(30); sel = 3'd2;
        at(48); chk_state("db_wait", 0, 0);
        at(49); chk_state("db_pend", 1, 0);
        at(55); chk_state("db_before", 1, 0);
        at(56); chk_state("db_switch", 0, 2);
        at(61);
`else
        push(2, 8, 0);
        rst_n = 1'b1;
        at(17); sel = 3'd3; push(1, 8, 1);
        at(19); chk_state("ovr_lat", 0, 0);
        at(20); chk_state("ovr_pend", 1, 0); sel = 3'd1;
        at(23); chk_state("ovr_hold", 1, 0);
        at(24); chk_state("ovr_switch", 0, 1);
        at(25); sel = 3'd0; push(3, 4, 1);
        at(27); chk_state("cxl_lat", 0, 1);
        at(28); chk_state("cxl_pend", 1, 1); sel = 3'd1;
        at(30); chk_state("cxl_hold", 1, 1);
        at(31); chk_state("cxl_clear", 0, 1);
        at(33); sel = 3'd2; push(1, 4, 2); push(5, 2, 2);
        at(35); chk_state("sw_lat", 0, 1);
        at(36); chk_state("sw_pend", 1, 1);
        at(39); chk_state("sw_wait", 1, 1);
        at(40); chk_state("sw_done", 0, 2);
        at(41); sel = 3'd5;
        at(44); chk_state("inv_a", 0, 2);
        at(46); chk_state("inv_b", 0, 2);
        at(47); sel = 3'd3; push(1, 2, 3); push(11, 1, 3);
        at(50); chk_state("div1_pend", 1, 2);
        at(52); chk_state("div1_switch", 0, 3);
        at(60); sel = 3'd0;
        at(63); chk_state("rst_pend", 1, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_clkout", clkOut, 0);
        chk_state("mid_rst", 0, 0);
        exp_ck = 0;
        push(2, 8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        at(20);
`endif
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want summary (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
